// File: rtl/dsp_chain_drain_acc_if.sv
// Stream interface for the DSP chain drain: free-running chain input and a
// buffered valid/ready result output.
interface dsp_chain_drain_acc_if #(
  parameter int IN_W  = 37,
  parameter int OUT_W = 16
);
  // Handshake: the chain side has no ready, so every in_valid term is consumed
  // in its cycle. The result side transfers the head when out_valid && out_ready
  // are both high on a rising clk edge. out_data/out_sat hold while
  // out_valid && !out_ready, and out_valid never drops without a transfer.
  logic                    in_valid;
  logic                    in_last;
  logic signed [IN_W-1:0]  chain_result;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  modport master (
    output in_valid,
    output in_last,
    output chain_result,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_sat
  );

  modport slave (
    input  in_valid,
    input  in_last,
    input  chain_result,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_sat
  );
endinterface

// File: rtl/dsp_chain_drain_acc.sv
// Tail consumer of a cascaded DSP chain: accumulates chainout terms per group,
// rounds/shifts/saturates each group total and buffers it in a small FIFO.
module dsp_chain_drain_acc #(
  parameter int IN_W       = 37,
  parameter int ACC_W      = 48,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_TERMS  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  dsp_chain_drain_acc_if.slave bus,
  output logic                 overflow_err,
  output logic                 len_err,
  output logic [15:0]          sat_cnt,
  output logic                 dbg_state
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int RND_W = ACC_W + 1;
  localparam int ENT_W = OUT_W + 1;

  // Rounding runs one bit wider than the accumulator so the bias cannot wrap.
  localparam logic signed [RND_W-1:0] HALF   = RND_W'(1) << (SHIFT - 1);
  localparam logic signed [RND_W-1:0] SAT_HI = (RND_W'(1) << (OUT_W - 1)) - RND_W'(1);
  localparam logic signed [RND_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] total;
  logic [CNT_W-1:0]        term_cnt;
  logic                    at_max;
  logic                    close;
  logic                    force_close;

  logic signed [RND_W-1:0] biased;
  logic signed [RND_W-1:0] rshift;
  logic [OUT_W-1:0]        rnd_data;
  logic                    rnd_sat;

  logic                    post_valid;
  logic [OUT_W-1:0]        post_data;
  logic                    post_sat;

  logic [ENT_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W:0]          wr_ptr;
  logic [PTR_W:0]          rd_ptr;
  logic [PTR_W-1:0]        wr_idx;
  logic [PTR_W-1:0]        rd_idx;
  logic [PTR_W-1:0]        head_idx;
  logic                    empty;
  logic                    full;
  logic                    pop;
  logic                    push_ok;
  logic                    drop;

  assign term_ext = {{(ACC_W - IN_W){bus.chain_result[IN_W-1]}}, bus.chain_result};
  assign sum      = acc + term_ext;
  assign at_max   = (term_cnt == CNT_W'(MAX_TERMS - 1));
  assign dbg_state = logic'(state);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.in_valid && !bus.in_last) begin
          state_nx = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.in_valid && (bus.in_last || at_max)) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    total       = term_ext;
    close       = 1'b0;
    force_close = 1'b0;
    case (state)
      S_IDLE: begin
        total = term_ext;
        close = bus.in_valid && bus.in_last;
      end
      S_ACCUM: begin
        total       = sum;
        close       = bus.in_valid && (bus.in_last || at_max);
        force_close = bus.in_valid && !bus.in_last && at_max;
      end
      default: begin
        total = term_ext;
      end
    endcase
  end

  // The first term of a group reloads the accumulator instead of adding.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      term_cnt <= '0;
    end else if (bus.in_valid) begin
      if (state == S_IDLE) begin
        acc      <= term_ext;
        term_cnt <= CNT_W'(1);
      end else begin
        acc      <= sum;
        term_cnt <= term_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    biased   = {total[ACC_W-1], total} + HALF;
    rshift   = biased >>> SHIFT;
    rnd_data = rshift[OUT_W-1:0];
    rnd_sat  = 1'b0;
    if (rshift > SAT_HI) begin
      rnd_data = {1'b0, {(OUT_W - 1){1'b1}}};
      rnd_sat  = 1'b1;
    end else if (rshift < SAT_LO) begin
      rnd_data = {1'b1, {(OUT_W - 1){1'b0}}};
      rnd_sat  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      post_valid <= 1'b0;
      post_data  <= '0;
      post_sat   <= 1'b0;
    end else begin
      post_valid <= close;
      if (close) begin
        post_data <= rnd_data;
        post_sat  <= rnd_sat;
      end
    end
  end

  assign wr_idx  = wr_ptr[PTR_W-1:0];
  assign rd_idx  = rd_ptr[PTR_W-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_idx == rd_idx) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign pop     = !empty && bus.out_ready;
  assign push_ok = post_valid && (!full || pop);
  assign drop    = post_valid && full && !pop;

  // While empty, the slot behind the read pointer still holds the last popped
  // entry, which gives the required hold-last-value output for free.
  assign head_idx = empty ? (rd_idx - PTR_W'(1)) : rd_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_err <= 1'b0;
      len_err      <= 1'b0;
      sat_cnt      <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_idx] <= {post_sat, post_data};
        wr_ptr      <= wr_ptr + (PTR_W + 1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
      end
      if (drop) begin
        overflow_err <= 1'b1;
      end
      if (force_close) begin
        len_err <= 1'b1;
      end
      if (push_ok && post_sat && (sat_cnt != 16'hFFFF)) begin
        sat_cnt <= sat_cnt + 16'd1;
      end
    end
  end

  assign bus.out_valid = !empty;
  assign {bus.out_sat, bus.out_data} = mem[head_idx];

endmodule
